// File: rtl/fetch_stage.sv
// Instruction-fetch front end: credit-limited pipelined imem requests, in-order word buffer, redirect flush.
// Optional FETCH_MISALIGN_CHECK_EN adds fetch_misaligned and a HALT state for misaligned redirect targets.
module fetch_stage #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    INSTRUCTION = 32,
  parameter int                    FIFO_DEPTH  = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [DATA_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ready,
  input  logic                   imem_rvalid,
  input  logic [INSTRUCTION-1:0] imem_rdata,
  input  logic                   redirect_en,
  input  logic [DATA_WIDTH-1:0]  redirect_pc,
  output logic [INSTRUCTION-1:0] instruction,
  output logic [DATA_WIDTH-1:0]  instr_pc,
  output logic                   instr_valid,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic                   fetch_misaligned,
`endif
  input  logic                   decode_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
`else
  typedef enum logic [0:0] {BOOT, RUN} state_t;
`endif

  state_t                  state, state_n;
  logic [DATA_WIDTH-1:0]   pc_next;
  logic [CW-1:0]           pending, discard, fifo_count;
  logic [AW-1:0]           fifo_wr, fifo_rd, pcq_wr, pcq_rd;
  logic [INSTRUCTION-1:0]  fifo_data [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   fifo_pc   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   pcq       [FIFO_DEPTH];

  logic                    resp, keep, pop, accept, credit_ok, misaligned;
  logic [CW:0]             live;
  logic [DATA_WIDTH-1:0]   redir_target;

  // Stale responses (discard>0) still occupy pending, so they are subtracted from the live occupancy.
  assign live      = {1'b0, fifo_count} + {1'b0, pending} - {1'b0, discard};
  assign credit_ok = (live < {1'b0, DEPTH_C}) && (pending < DEPTH_C);
  assign resp      = imem_rvalid && (pending != '0);
  assign keep      = resp && (discard == '0) && !redirect_en;
  assign pop       = instr_valid && decode_ready;
  assign accept    = imem_req && imem_ready;
  assign imem_addr = pc_next;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misaligned   = (redirect_pc[1:0] != 2'b00);
  assign redir_target = redirect_pc;
`else
  assign misaligned   = 1'b0;
  assign redir_target = redirect_pc & ~DATA_WIDTH'(3);
`endif

  assign instr_valid = (fifo_count != '0);
  assign instruction = instr_valid ? fifo_data[fifo_rd] : '0;
  assign instr_pc    = instr_valid ? fifo_pc[fifo_rd]   : '0;

  always_comb begin
    state_n  = state;
    imem_req = 1'b0;
    case (state)
      BOOT: state_n = (redirect_en && misaligned) ? state_t'(2) : RUN;
      RUN: begin
        imem_req = credit_ok && !redirect_en;
        if (redirect_en && misaligned) state_n = state_t'(2);
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      HALT: if (redirect_en && !misaligned) state_n = RUN;
`endif
      default: state_n = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= BOOT;
      pc_next    <= RESET_PC;
      pending    <= '0;
      discard    <= '0;
      fifo_count <= '0;
      fifo_wr    <= '0;
      fifo_rd    <= '0;
      pcq_wr     <= '0;
      pcq_rd     <= '0;
    end else begin
      state   <= state_n;
      pending <= pending + CW'(accept) - CW'(resp);
      if (redirect_en) begin
        pc_next    <= redir_target;
        discard    <= pending - CW'(resp);
        fifo_count <= '0;
        fifo_wr    <= '0;
        fifo_rd    <= '0;
        pcq_wr     <= '0;
        pcq_rd     <= '0;
      end else begin
        if (accept) begin
          pc_next <= pc_next + DATA_WIDTH'(4);
          pcq_wr  <= pcq_wr + 1'b1;
        end
        if (resp && discard != '0) discard <= discard - 1'b1;
        if (keep) begin
          pcq_rd  <= pcq_rd + 1'b1;
          fifo_wr <= fifo_wr + 1'b1;
        end
        if (pop) fifo_rd <= fifo_rd + 1'b1;
        fifo_count <= fifo_count + CW'(keep) - CW'(pop);
      end
    end
  end

  // Payload storage carries no reset; occupancy counters qualify every read.
  always_ff @(posedge clk) begin
    if (accept) pcq[pcq_wr] <= pc_next;
    if (keep) begin
      fifo_data[fifo_wr] <= imem_rdata;
      fifo_pc[fifo_wr]   <= pcq[pcq_rd];
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fetch_misaligned <= 1'b0;
    else      fetch_misaligned <= (state_n == HALT);
  end
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the rv32i pipeline. It is the producer side of the decode stage's `instruction` input.
- Generates sequential PCs and issues pipelined requests to instruction memory.
- Buffers the returned words in a small in-order FIFO and presents them to decode with a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes buffered and in-flight fetches.

Parameters:
- DATA_WIDTH, 32, address/PC width.
- INSTRUCTION, 32, instruction word width.
- FIFO_DEPTH, 2, instruction buffer entries; also the maximum outstanding memory requests (power of two, ≥2).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- imem_req  output  1  request valid to instruction memory.
- imem_addr  output  DATA_WIDTH  request word address (byte address, [1:0]=0).
- imem_ready  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  read data valid; responses return in request order, latency ≥1 cycle.
- imem_rdata  input  INSTRUCTION  read data.
- redirect_en  input  1  pulse; restart fetch at redirect_pc.
- redirect_pc  input  DATA_WIDTH  redirect target.
- instruction  output  INSTRUCTION  head-of-FIFO word to decode.
- instr_pc  output  DATA_WIDTH  PC of `instruction`.
- instr_valid  output  1  `instruction`/`instr_pc` valid.
- decode_ready  input  1  decode consumes the head entry when instr_valid=1.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc_next=RESET_PC; FIFO empty.
  - pending=0, discard=0.
  - imem_req=0, instr_valid=0, instruction=0, instr_pc=0.
  - FSM=BOOT.
- FSM states:
  - BOOT: one cycle after reset release, no request; then go to RUN.
  - RUN: normal fetch.
  - HALT: used only with the optional feature.
- Request issue in RUN:
  - imem_req=1 iff (fifo_count + pending − discard) < FIFO_DEPTH, pending < FIFO_DEPTH, and redirect_en=0.
  - imem_addr=pc_next.
  - On imem_req && imem_ready: pc_next += 4 (modulo 2^DATA_WIDTH, wraps at 32'hFFFF_FFFC → 0) and pending += 1.
  - The request is held stable (same addr) until accepted unless a redirect occurs.
- Response handling:
  - On imem_rvalid: pending −= 1.
  - If discard>0, the word is dropped and discard −= 1.
  - Otherwise {imem_rdata, pc of that request} is written to the FIFO. A parallel PC queue tracks request order.
  - The credit rule guarantees the FIFO never overflows. An rvalid with pending=0 is a protocol error and is ignored.
- Decode side:
  - instr_valid = FIFO non-empty. There is no bypass, so a word is visible the cycle after its imem_rvalid.
  - A pop happens when instr_valid && decode_ready.
  - A push and a pop in the same cycle on a full FIFO are both legal.
  - instruction and instr_pc are stable while instr_valid=1 and decode_ready=0.
- Redirect (redirect_en=1):
  - Next edge: FIFO flushed (instr_valid=0 next cycle) and pc_next=redirect_pc.
  - discard = pending minus any response arriving that same cycle, i.e. that response is stale too and is dropped.
  - imem_req is forced 0 in the redirect cycle. The first request to the target is issued the following cycle.
  - A redirect while the FIFO is empty and nothing is pending only reloads pc_next.
  - Back-to-back redirects: the last one wins, and discard accumulates correctly.
- Counters pending and discard are each $clog2(FIFO_DEPTH)+1 bits wide.
- Reset mid-operation: all in-flight state is dropped. Memory responses arriving before BOOT ends are ignored (pending=0).

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- With the macro defined:
  - Adds output port fetch_misaligned (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]≠0 flushes as normal but enters HALT: no requests, fetch_misaligned=1.
  - HALT is left only by a redirect to an aligned target (→RUN, flag cleared) or by reset.
- Without the macro: no port, no HALT state; redirect_pc[1:0] is forced to 0.

Test Plan:
- Reset release, memory with 1-cycle latency and imem_ready=1, decode_ready=1 → addrs 0x0,0x4,0x8… issued; instr_valid rises 3 cycles after reset release (BOOT, request, response) with instr_pc=0x0; thereafter one instruction per cycle.
- decode_ready=0 for 10 cycles → at most 2 requests outstanding or buffered; imem_req drops; head stays instruction@0x0 unchanged; resuming delivers 0x0,0x4,0x8 in order with no gaps or duplicates.
- 3-cycle latency, two requests in flight, redirect_en to 0x100 → both stale responses dropped; next delivered instr_pc=0x100, then 0x104.
- Redirect in the same cycle as imem_rvalid of the 0x8 fetch → the 0x8 word is never presented; first valid after the redirect is at the target PC.
- RESET_PC=32'hFFFF_FFF8 → fetch sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- FETCH_MISALIGN_CHECK_EN defined, redirect to 0x102 → fetch_misaligned=1, imem_req=0 indefinitely; redirect to 0x200 → flag clears; fetch resumes at 0x200.
